// File: rtl/accum_ctrl_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/WAIT/HALT controller for the accumulator datapath.
// Optional illegal-opcode trap enabled by defining ACCUM_CTRL_ILLEGAL_TRAP_EN.
module accum_ctrl_mc #(
  parameter int ARG_W       = 4,
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ARG_W+3:0]  instr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              Zero,
  input  logic              Carry,
  output logic              LoadIR,
  output logic              IncPC,
  output logic              SelPC,
  output logic              LoadPC,
  output logic              LoadReg,
  output logic              DumpReg,
  output logic              LoadAcc,
  output logic              DumpAcc,
  output logic [1:0]        SelAcc,
  output logic [3:0]        SelALU,
  output logic [DATA_W-1:0] ImmediateData,
  output logic [REG_AW-1:0] RegNumber,
  output logic              halted,
  output logic              illegal,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // WAIT counts down from WAIT_CYCLES-1 to 0, so 15 fits the 4-bit counter.
  localparam logic [3:0] WAIT_LAST  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam state_t     POST_EXEC  = (WAIT_CYCLES > 0) ? S_WAIT : S_FETCH;

  state_t             cur;
  state_t             nxt;
  logic [ARG_W+3:0]   ir;
  logic               zero_f;
  logic               carry_f;
  logic [3:0]         wait_cnt;
  logic               req_c;
  logic               illegal_set;
  logic [3:0]         opcode;
  logic [ARG_W-1:0]   arg;

  assign opcode        = ir[ARG_W+3:ARG_W];
  assign arg           = ir[ARG_W-1:0];
  assign ImmediateData = DATA_W'(arg);
  assign RegNumber     = arg[REG_AW-1:0];
  assign state         = cur;
  // Request is held off while reset is asserted so it first rises after release.
  assign imem_req      = req_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      ir       <= '0;
      zero_f   <= 1'b0;
      carry_f  <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && imem_ack) ir <= instr;
      if (cur == S_DECODE) begin
        zero_f  <= Zero;
        carry_f <= Carry;
      end
      if (cur == S_EXEC) wait_cnt <= WAIT_LAST;
      else if (cur == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
    end
  end

`ifdef ACCUM_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    nxt         = cur;
    req_c       = 1'b0;
    LoadIR      = 1'b0;
    IncPC       = 1'b0;
    SelPC       = 1'b0;
    LoadPC      = 1'b0;
    LoadReg     = 1'b0;
    DumpReg     = 1'b0;
    LoadAcc     = 1'b0;
    DumpAcc     = 1'b0;
    SelAcc      = 2'b00;
    SelALU      = 4'b0000;
    halted      = 1'b0;
    illegal_set = 1'b0;
    case (cur)
      S_FETCH: begin
        req_c = 1'b1;
        if (imem_ack) nxt = S_DECODE;
      end
      S_DECODE: begin
        LoadIR = 1'b1;
        nxt    = S_EXEC;
      end
      S_EXEC: begin
        nxt = POST_EXEC;
        case (opcode)
          4'h0: IncPC = 1'b1;
          4'h1, 4'h2, 4'h3: begin
            DumpReg = 1'b1;
            LoadAcc = 1'b1;
            SelAcc  = 2'b10;
            IncPC   = 1'b1;
            SelALU  = (opcode == 4'h1) ? 4'b0000 :
                      (opcode == 4'h2) ? 4'b0001 : 4'b1000;
          end
          4'hB, 4'hC: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'b10;
            IncPC   = 1'b1;
            SelALU  = (opcode == 4'hB) ? 4'b1101 : 4'b1100;
          end
          4'h4: begin
            DumpReg = 1'b1;
            LoadAcc = 1'b1;
            SelAcc  = 2'b01;
            IncPC   = 1'b1;
          end
          4'h5: begin
            DumpAcc = 1'b1;
            LoadReg = 1'b1;
            IncPC   = 1'b1;
          end
          4'hD: begin
            LoadAcc = 1'b1;
            IncPC   = 1'b1;
          end
          // Jumps use the flags captured in DECODE, never the live inputs.
          4'h6, 4'h7: begin
            LoadPC = zero_f;
            SelPC  = zero_f & (opcode == 4'h7);
            IncPC  = ~zero_f;
          end
          4'h8, 4'hA: begin
            LoadPC = carry_f;
            SelPC  = carry_f & (opcode == 4'hA);
            IncPC  = ~carry_f;
          end
          4'hF: nxt = S_HALT;
          default: begin
`ifdef ACCUM_CTRL_ILLEGAL_TRAP_EN
            illegal_set = 1'b1;
            nxt         = S_HALT;
`else
            IncPC = 1'b1;
`endif
          end
        endcase
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: doc/accum_ctrl_mc.md
# accum_ctrl_mc

Parametrised multi-cycle controller for the accumulator datapath: fetches an instruction through a req/ack handshake, decodes it, and issues one-cycle control strobes to the PC, register file, accumulator muxes and ALU. It sits between instruction memory and the datapath. Relative to the first-generation controller it adds:
- configurable operand and data width;
- a fetch handshake;
- programmable post-execute wait states;
- flags latched in decode;
- ALU results written back to the accumulator;
- a sticky HALT state and illegal-opcode handling.

## Interface
Clock is `clk`, reset is `reset`; one clock, synchronous active-high reset.

Parameters:
- ARG_W, 4: operand field width; the instruction is {opcode[3:0], arg[ARG_W-1:0]}.
- DATA_W, 8: ImmediateData width; must satisfy DATA_W ≥ ARG_W.
- REG_AW, 4: RegNumber width; must satisfy REG_AW ≤ ARG_W.
- WAIT_CYCLES, 0: idle cycles after EXEC, range 0–15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr  in  4+ARG_W  instruction word; valid when imem_ack is high
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch acknowledge
- Zero  in  1  accumulator zero flag
- Carry  in  1  ALU carry flag
- LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc, DumpAcc  out  1 each  control strobes
- SelAcc  out  2  accumulator input select: 00 = immediate, 01 = register, 10 = ALU
- SelALU  out  4  ALU operation: 0000 add, 0001 sub, 1000 nor, 1100 shr, 1101 shl
- ImmediateData  out  DATA_W  zero-extended arg
- RegNumber  out  REG_AW  arg[REG_AW-1:0]
- halted  out  1  controller is in HALT
- illegal  out  1  sticky; set on an illegal opcode

## Operation
States: FETCH, DECODE, EXEC, WAIT, HALT.

**FETCH**
- imem_req = 1.
- On a cycle where imem_ack = 1: latch instr into the internal IR and go to DECODE.
- Otherwise stay in FETCH.

**DECODE**
- LoadIR = 1 for this single cycle.
- Zero and Carry are sampled into flag registers at the end of this cycle.
- Next state is EXEC.

**EXEC** (one cycle)
Strobes are decoded from the IR and the latched flags; all strobes not listed for an opcode are 0.
- 0000 NOP: IncPC.
- 0001 ADD, 0010 SUB, 0011 NOR: DumpReg, LoadAcc, SelAcc = 10, SelALU per the op, IncPC.
- 1011 SHL, 1100 SHR: LoadAcc, SelAcc = 10, SelALU = 1101 / 1100, IncPC.
- 0100 LDR: DumpReg, LoadAcc, SelAcc = 01, IncPC.
- 0101 STR: DumpAcc, LoadReg, IncPC.
- 1101 LDI: LoadAcc, SelAcc = 00, IncPC.
- Conditional jumps:
  - 0110 JZR: register target, condition Zero.
  - 0111 JZI: immediate target, condition Zero.
  - 1000 JCR: register target, condition Carry.
  - 1010 JCI: immediate target, condition Carry.
  - Taken: LoadPC = 1, SelPC = 0 for register target, 1 for immediate target. IncPC = 0.
  - Not taken: IncPC only.
- 1111 HALT: no strobes. Next state is HALT.
- 1001, 1110 illegal: handled per Configuration.

**After EXEC**
- Go to WAIT if WAIT_CYCLES > 0, else to FETCH.
- WAIT holds for exactly WAIT_CYCLES cycles with all strobes at 0, then goes to FETCH.

**Outputs in the same cycle**
- RegNumber and ImmediateData are driven from the IR in every state after DECODE.
- SelALU and SelAcc hold 0 outside EXEC.

**HALT**
- Absorbing state.
- halted = 1, imem_req = 0, all strobes 0.
- Left only by reset.

## Timing
- Moore outputs: every strobe is a function of state and IR only, so no output changes combinationally with imem_ack, Zero or Carry.
- Reset values: state FETCH, IR 0, flags 0, all outputs 0 (including imem_req, halted and illegal).
  - imem_req rises in the first cycle after reset is deasserted.
- Latency with ack in the first FETCH cycle: FETCH 1 + DECODE 1 + EXEC 1 + WAIT_CYCLES.
  - With WAIT_CYCLES = 0 that is 3 cycles per instruction.
  - Each cycle imem_ack is low adds one FETCH cycle.
- Handshake:
  - imem_req stays high until the ack cycle and is low from the next cycle.
  - imem_ack outside FETCH is ignored.
- Flags: only values present during the DECODE cycle matter. Flag changes during EXEC do not alter the jump decision.
- Reset mid-operation: takes effect at the next edge from any state, including HALT. Strobes are 0 in the following cycle, and a pending fetch or wait is discarded.
- The WAIT counter is 4 bits; it does not wrap with WAIT_CYCLES = 15.

## Configuration
Macro: ACCUM_CTRL_ILLEGAL_TRAP_EN.
- **Defined:** an illegal opcode in EXEC sets `illegal`, issues no strobes and goes to HALT. `illegal` and `halted` stay 1 until reset.
- **Undefined:** an illegal opcode executes as NOP (IncPC only), and `illegal` is tied to 0.

## Test plan
1. Reset, then LDI 0x5 with imem_ack tied high and WAIT_CYCLES = 0.
   - Required: imem_req in cycle 1 after reset, LoadIR in cycle 2.
   - Required in cycle 3: LoadAcc = 1, SelAcc = 00, ImmediateData = 0x05, IncPC = 1.
   - Required: next FETCH in cycle 4.
2. ADD r3 with imem_ack delayed 3 cycles.
   - Required: imem_req high for 4 cycles, then DECODE.
   - Required in EXEC: DumpReg = 1, LoadAcc = 1, SelAcc = 10, SelALU = 0000, RegNumber = 3.
3. JZI with Zero = 1 during DECODE and Zero = 0 during EXEC.
   - Required: LoadPC = 1, SelPC = 1, IncPC = 0.
   - Repeat with Zero = 0 during DECODE; required: IncPC = 1 only.
4. JCR with Carry = 1, WAIT_CYCLES = 2.
   - Required: LoadPC = 1, SelPC = 0.
   - Required: exactly 2 all-zero WAIT cycles before imem_req.
5. HALT, then 10 cycles of imem_ack = 1, then reset.
   - Required: halted = 1 with no strobes and imem_req = 0 throughout.
   - Required after reset: state FETCH, halted = 0.
6. Opcode 1001 with the macro defined.
   - Required: illegal = 1, halted = 1, no IncPC.
   - With the macro undefined: IncPC = 1, illegal = 0, next fetch proceeds.
